rx_pixel_ctrl: RTL and testbench

- Sequences the UART receive block: detects its data_ready flag, pulses data_read to drain each byte, and checks the error flags.
- Packs NUM_BYTES consecutive good bytes, first byte in the least-significant position, into one pixel word for the daltonization datapath.
- Discards partial pixels on line errors or inter-byte timeout so the pixel stream stays byte-aligned.

---
 rtl/rx_pixel_ctrl.sv | 165 ++++++++++++++++
 tb/tb_rx_pixel_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_pixel_ctrl.sv
// UART receive sequencer: drains bytes, checks line flags, packs NUM_BYTES bytes into a pixel.
// Optional saturating error counter (err_count / err_clr) is built when RX_PIXEL_ERR_CNT_EN is defined.
module rx_pixel_ctrl #(
   parameter int NUM_BYTES      = 3,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             rx_data,
   input  logic                   data_ready,
   input  logic                   overrun_error,
   input  logic                   framing_error,
   output logic                   data_read,
   output logic [8*NUM_BYTES-1:0] pixel,
   output logic                   pix_valid,
   input  logic                   pix_ready,
   output logic                   err_pulse,
   output logic [1:0]             err_code,
   output logic                   busy
`ifdef RX_PIXEL_ERR_CNT_EN
   ,
   input  logic                   err_clr,
   output logic [7:0]             err_count
`endif
);

   localparam logic [1:0]  LAST_IDX = 2'(NUM_BYTES - 1);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ERR_FRAMING = 2'b01;
   localparam logic [1:0] ERR_OVERRUN = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {
      S_WAIT = 2'd0,
      S_ACK  = 2'd1,
      S_CHK  = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [1:0]  r_byte_idx, w_idx_nxt;
   logic [15:0] r_timer, w_timer_nxt;
   logic        r_pix_valid, w_pix_valid_nxt;
   logic        r_err_pulse, w_err_pulse_nxt;
   logic [1:0]  r_err_code, w_err_code_nxt;
   logic [7:0]  r_hold_data;
   logic        r_hold_fe, r_hold_oe;
   logic        w_capture;
   logic        w_lane_we;
   logic [8*NUM_BYTES-1:0] r_pixel;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_WAIT;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_idx_nxt       = r_byte_idx;
      w_timer_nxt     = r_timer;
      w_pix_valid_nxt = r_pix_valid;
      w_err_pulse_nxt = 1'b0;
      w_err_code_nxt  = r_err_code;
      w_capture       = 1'b0;
      w_lane_we       = 1'b0;
      case (r_state)
         S_WAIT: begin
            // A byte arriving on the timeout cycle takes priority over the timeout.
            if (data_ready) begin
               w_capture   = 1'b1;
               w_state_nxt = S_ACK;
            end else if (r_byte_idx != 2'd0) begin
               if (r_timer == TO_LAST) begin
                  w_idx_nxt       = 2'd0;
                  w_timer_nxt     = 16'd0;
                  w_err_pulse_nxt = 1'b1;
                  w_err_code_nxt  = ERR_TIMEOUT;
               end else begin
                  w_timer_nxt = r_timer + 16'd1;
               end
            end
         end
         S_ACK: w_state_nxt = S_CHK;
         S_CHK: begin
            w_timer_nxt = 16'd0;
            w_state_nxt = S_WAIT;
            if (r_hold_oe) begin
               w_idx_nxt       = 2'd0;
               w_err_pulse_nxt = 1'b1;
               w_err_code_nxt  = ERR_OVERRUN;
            end else if (r_hold_fe) begin
               w_idx_nxt       = 2'd0;
               w_err_pulse_nxt = 1'b1;
               w_err_code_nxt  = ERR_FRAMING;
            end else begin
               w_lane_we = 1'b1;
               if (r_byte_idx == LAST_IDX) begin
                  w_idx_nxt       = 2'd0;
                  w_pix_valid_nxt = 1'b1;
                  w_state_nxt     = S_OUT;
               end else begin
                  w_idx_nxt = r_byte_idx + 2'd1;
               end
            end
         end
         S_OUT: begin
            // data_ready is deliberately not looked at here; the byte waits in the receiver.
            if (pix_ready) begin
               w_pix_valid_nxt = 1'b0;
               w_state_nxt     = S_WAIT;
            end
         end
         default: w_state_nxt = S_WAIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_byte_idx  <= 2'd0;
         r_timer     <= 16'd0;
         r_pix_valid <= 1'b0;
         r_err_pulse <= 1'b0;
         r_err_code  <= 2'b00;
         r_hold_data <= 8'd0;
         r_hold_fe   <= 1'b0;
         r_hold_oe   <= 1'b0;
      end else begin
         r_byte_idx  <= w_idx_nxt;
         r_timer     <= w_timer_nxt;
         r_pix_valid <= w_pix_valid_nxt;
         r_err_pulse <= w_err_pulse_nxt;
         r_err_code  <= w_err_code_nxt;
         if (w_capture) begin
            r_hold_data <= rx_data;
            r_hold_fe   <= framing_error;
            r_hold_oe   <= overrun_error;
         end
      end
   end

   for (genvar g = 0; g < NUM_BYTES; g++) begin : g_lane
      always_ff @(posedge clk) begin
         if (rst)                                      r_pixel[g*8 +: 8] <= 8'd0;
         else if (w_lane_we && r_byte_idx == 2'(g))    r_pixel[g*8 +: 8] <= r_hold_data;
      end
   end

`ifdef RX_PIXEL_ERR_CNT_EN
   logic [7:0] r_err_count;
   always_ff @(posedge clk) begin
      if (rst || err_clr)                          r_err_count <= 8'd0;
      else if (r_err_pulse && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
   end
   assign err_count = r_err_count;
`endif

   assign data_read = (r_state == S_ACK);
   assign pixel     = r_pixel;
   assign pix_valid = r_pix_valid;
   assign err_pulse = r_err_pulse;
   assign err_code  = r_err_code;
   assign busy      = (r_byte_idx != 2'd0) || r_pix_valid;

endmodule

// File: tb/tb_rx_pixel_ctrl.sv
// Scoreboard bench for rx_pixel_ctrl: a byte-list reference model feeds expected pixel/error queues.
module tb_rx_pixel_ctrl;
   localparam int NB = 3;
   localparam int TO = 20;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    rx_data;
   logic          data_ready, overrun_error, framing_error;
   logic          data_read;
   logic [8*NB-1:0] pixel;
   logic          pix_valid, pix_ready;
   logic          err_pulse;
   logic [1:0]    err_code;
   logic          busy;
`ifdef RX_PIXEL_ERR_CNT_EN
   logic          err_clr;
   logic [7:0]    err_count;
`endif

   rx_pixel_ctrl #(.NUM_BYTES(NB), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .data_ready(data_ready),
      .overrun_error(overrun_error), .framing_error(framing_error),
      .data_read(data_read), .pixel(pixel), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .err_pulse(err_pulse), .err_code(err_code), .busy(busy)
`ifdef RX_PIXEL_ERR_CNT_EN
      , .err_clr(err_clr), .err_count(err_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [8*NB-1:0] exp_pix_q[$];
   logic [1:0]      exp_err_q[$];
   logic [7:0]      part[$];
   logic hold_pr = 1'b0;
   logic rand_pr = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: good bytes accumulate in a list; any error empties it; a full list is a pixel.
   task automatic model_byte(input logic [7:0] d, input logic fe, input logic oe);
      logic [8*NB-1:0] p;
      if (oe) begin
         exp_err_q.push_back(2'b10); part.delete();
      end else if (fe) begin
         exp_err_q.push_back(2'b01); part.delete();
      end else begin
         part.push_back(d);
         if (part.size() == NB) begin
            p = '0;
            for (int i = 0; i < NB; i++) p[i*8 +: 8] = part[i];
            exp_pix_q.push_back(p);
            part.delete();
         end
      end
   endtask

   task automatic wait_read(output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (!data_read && n < 400);
      chk("data_read_seen", {31'd0, data_read}, 32'd1);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic fe, input logic oe);
      int n;
      model_byte(d, fe, oe);
      @(negedge clk);
      rx_data = d; framing_error = fe; overrun_error = oe; data_ready = 1'b1;
      wait_read(n);
      data_ready = 1'b0; framing_error = 1'b0; overrun_error = 1'b0;
   endtask

   // g negedges after the previous drain; a partial pixel times out once g >= TO+2.
   task automatic gap_send(input int g, input logic [7:0] d, input logic fe, input logic oe);
      if (part.size() != 0 && g >= TO + 2) begin
         exp_err_q.push_back(2'b11); part.delete();
      end
      repeat (g - 1) @(negedge clk);
      send_byte(d, fe, oe);
   endtask

   initial begin
      pix_ready = 1'b1;
      forever begin
         @(negedge clk); #1;
         pix_ready = hold_pr ? 1'b0 : (rand_pr ? ($urandom_range(0, 3) != 0) : 1'b1);
      end
   end

   // Monitor: pops expectations whenever the DUT presents a pixel or an error strobe.
   initial begin
      logic prev_pv = 1'b0, prev_pr = 1'b0, prev_dr = 1'b0;
      logic [8*NB-1:0] prev_pix = '0;
      forever begin
         @(negedge clk); #2;
         if (!rst) begin
            if (pix_valid && prev_pv && !prev_pr) chk("pixel_hold", 32'(pixel), 32'(prev_pix));
            if (pix_valid && pix_ready) begin
               if (exp_pix_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_pixel: got %0h expected none", pixel);
               end else chk("pixel", 32'(pixel), 32'(exp_pix_q.pop_front()));
            end
            if (err_pulse) begin
               chk("err_vs_pix_valid", {31'd0, pix_valid}, 32'd0);
               if (exp_err_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_err: got code %0d expected none", err_code);
               end else chk("err_code", {30'd0, err_code}, {30'd0, exp_err_q.pop_front()});
            end
            if (data_read) begin
               chk("data_read_not_in_out", {31'd0, pix_valid}, 32'd0);
               chk("data_read_one_cycle", {31'd0, prev_dr}, 32'd0);
            end
         end
         prev_pv = pix_valid; prev_pr = pix_ready; prev_dr = data_read; prev_pix = pixel;
      end
   end

   initial begin
      int n;
      logic [8*NB-1:0] held;
      logic fe, oe;
      int g, r;
      rst = 1'b1; rx_data = 8'd0; data_ready = 1'b0; overrun_error = 1'b0; framing_error = 1'b0;
`ifdef RX_PIXEL_ERR_CNT_EN
      err_clr = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_data_read", {31'd0, data_read}, 32'd0);
      chk("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
      chk("rst_pixel", 32'(pixel), 32'd0);
      chk("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
      chk("rst_err_code", {30'd0, err_code}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;

      // Good pixel with latency check
      send_byte(8'h12, 1'b0, 1'b0);
      send_byte(8'h34, 1'b0, 1'b0);
      send_byte(8'h56, 1'b0, 1'b0);
      @(negedge clk); chk("lat_chk_cycle", {31'd0, pix_valid}, 32'd0);
      @(negedge clk); chk("lat_out_cycle", {31'd0, pix_valid}, 32'd1);
      chk("first_pixel", 32'(pixel), 32'h563412);
      @(negedge clk); chk("pix_valid_one_cycle", {31'd0, pix_valid}, 32'd0);

      // Framing error on second byte
      send_byte(8'hAA, 1'b0, 1'b0);
      send_byte(8'hBB, 1'b1, 1'b0);
      send_byte(8'h01, 1'b0, 1'b0);
      send_byte(8'h02, 1'b0, 1'b0);
      send_byte(8'h03, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("framing_code_held", {30'd0, err_code}, 32'd1);

      // Overrun with framing on the same byte
      send_byte(8'hCC, 1'b0, 1'b0);
      send_byte(8'hDD, 1'b1, 1'b1);
      @(negedge clk); @(negedge clk);
      chk("ovr_pulse", {31'd0, err_pulse}, 32'd1);
      chk("ovr_code", {30'd0, err_code}, 32'd2);
      chk("ovr_busy", {31'd0, busy}, 32'd0);

      // Timeout after one byte
      send_byte(8'h77, 1'b0, 1'b0);
      exp_err_q.push_back(2'b11); part.delete();
      n = 0;
      do begin @(negedge clk); n++; end while (!err_pulse && n < 60);
      chk("timeout_latency", n, TO + 2);
      chk("timeout_busy", {31'd0, busy}, 32'd0);
      repeat (5) @(negedge clk);
      send_byte(8'h21, 1'b0, 1'b0);
      send_byte(8'h22, 1'b0, 1'b0);
      send_byte(8'h23, 1'b0, 1'b0);

      // Timeout boundary: byte on the timeout cycle wins, one cycle later it does not
      repeat (4) @(negedge clk);
      send_byte(8'h31, 1'b0, 1'b0);
      gap_send(TO + 1, 8'h32, 1'b0, 1'b0);
      gap_send(TO + 2, 8'h33, 1'b0, 1'b0);
      gap_send(1, 8'h34, 1'b0, 1'b0);
      gap_send(1, 8'h35, 1'b0, 1'b0);
      repeat (4) @(negedge clk);

      // Backpressure
      hold_pr = 1'b1;
      send_byte(8'hA1, 1'b0, 1'b0);
      send_byte(8'hB2, 1'b0, 1'b0);
      send_byte(8'hC3, 1'b0, 1'b0);
      n = 0;
      while (!pix_valid && n < 10) begin @(negedge clk); n++; end
      held = pixel;
      chk("bp_pixel", 32'(held), 32'hC3B2A1);
      model_byte(8'hD4, 1'b0, 1'b0);
      rx_data = 8'hD4; data_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_stable", 32'(pixel), 32'(held));
         chk("bp_no_read", {31'd0, data_read}, 32'd0);
      end
      hold_pr = 1'b0;
      wait_read(n);
      chk("bp_read_after_accept", n, 2);
      data_ready = 1'b0;
      send_byte(8'hE5, 1'b0, 1'b0);
      send_byte(8'hF6, 1'b0, 1'b0);

      // Reset mid-pixel
      send_byte(8'h41, 1'b0, 1'b0);
      send_byte(8'h42, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1; part.delete();
      @(negedge clk);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_err_code", {30'd0, err_code}, 32'd0);
      chk("mid_rst_pixel", 32'(pixel), 32'd0);
      chk("mid_rst_err_pulse", {31'd0, err_pulse}, 32'd0);
      rst = 1'b0;
      send_byte(8'h51, 1'b0, 1'b0);
      send_byte(8'h52, 1'b0, 1'b0);
      send_byte(8'h53, 1'b0, 1'b0);

      // Randomized traffic with random backpressure and occasional long gaps
      rand_pr = 1'b1;
      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 9);
         if (r < 7)       g = $urandom_range(1, 5);
         else if (r == 7) g = TO + 1;
         else if (r == 8) g = TO + 2;
         else             g = TO + 10;
         fe = ($urandom_range(0, 11) == 0);
         oe = ($urandom_range(0, 11) == 0);
         gap_send(g, 8'($urandom), fe, oe);
      end
      if (part.size() != 0) begin
         exp_err_q.push_back(2'b11); part.delete();
      end
      repeat (TO + 40) @(negedge clk);
      rand_pr = 1'b0;
      repeat (4) @(negedge clk);

`ifdef RX_PIXEL_ERR_CNT_EN
      for (int i = 0; i < 300; i++) send_byte(8'h00, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      chk("err_count_sat", {24'd0, err_count}, 32'd255);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("err_count_clr", {24'd0, err_count}, 32'd0);
`endif

      chk("pix_q_drained", exp_pix_q.size(), 0);
      chk("err_q_drained", exp_err_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
